// File: rtl/m92_pkg.sv
// m92_pkg: shared types and constants for the M92 interrupt controller front-end.
//   - inta_state_e : INTA handshake FSM states
//   - IRQ_*        : pending-bit index of each local interrupt source
//   - REG_*        : register-select values on the `a` bus
package m92_pkg;

    localparam int unsigned NUM_SRC    = 4;
    localparam int unsigned IRQ_VBLANK = 0;
    localparam int unsigned IRQ_DMA    = 1;
    localparam int unsigned IRQ_RASTER = 2;
    localparam int unsigned IRQ_SOUND  = 3;

    localparam int unsigned RASTER_W = 9;
    localparam logic [RASTER_W-1:0] RASTER_RESET = 9'h1FF;

    localparam logic [1:0] REG_RASTER_LO = 2'd0;
    localparam logic [1:0] REG_RASTER_HI = 2'd1;
    localparam logic [1:0] REG_PEND_CLR  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK1,
        ST_ACK2,
        ST_WAIT
    } inta_state_e;

endpackage

// File: rtl/m92_irq_source.sv
// m92_irq_source: one interrupt source - rising-edge detect plus pending flag.
//   clk, reset : clock, async active-high reset
//   ce         : clock enable
//   src        : raw source level
//   clr        : clear request (register write or auto-clear); a new edge wins
//   pend       : registered pending flag
module m92_irq_source (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic src,
    input  logic clr,
    output logic pend
);

    logic prev_q, prev_d;
    logic pend_q, pend_d;

    // Edge detect and set-over-clear priority
    always_comb begin
        prev_d = prev_q;
        pend_d = pend_q;
        if (ce) begin
            prev_d = src;
            if (src && !prev_q) begin
                pend_d = 1'b1;
            end else if (clr) begin
                pend_d = 1'b0;
            end
        end
    end

    // History resets low so a level already high at reset release counts once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/m92_int_ctrl.sv
// m92_int_ctrl: M92 interrupt front-end. Latches video/DMA/sound/raster events
// into PIC request lines and sequences the CPU two-pulse INTA handshake.
// Optional feature macro: M92_RASTER_IRQ_EN (raster compare register + P2 source).
//   clk, reset, ce      : clock, async active-high reset, clock enable
//   cs, wr, a, din      : register write port (raster lo/hi, pending clear)
//   vblank, vcount      : video timing
//   dma_done, snd_irq   : sprite DMA / sound latch levels
//   ext_intp            : registered through to intp[7:4]
//   intp                : PIC request inputs
//   pic_int_req/vector  : PIC request and vector; pic_int_ack back to PIC
//   cpu_int, cpu_inta   : CPU INT pin and INTA strobe
//   cpu_vector(_oe)     : vector byte for the CPU data bus and its enable
module m92_int_ctrl
    import m92_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       cs,
    input  logic       wr,
    input  logic [1:0] a,
    input  logic [7:0] din,
    input  logic       vblank,
    input  logic [8:0] vcount,
    input  logic       dma_done,
    input  logic       snd_irq,
    input  logic [3:0] ext_intp,
    output logic [7:0] intp,
    input  logic       pic_int_req,
    input  logic [8:0] pic_int_vector,
    output logic       pic_int_ack,
    output logic       cpu_int,
    input  logic       cpu_inta,
    output logic [7:0] cpu_vector,
    output logic       cpu_vector_oe
);

    inta_state_e state_q, state_d;
    logic        cpu_int_q, cpu_int_d;
    logic        ack_q, ack_d;
    logic        oe_q, oe_d;
    logic [7:0]  vec_q, vec_d;
    logic [3:0]  ext_q, ext_d;

    logic               reg_wr_c;
    logic               raster_match_c;
    logic [NUM_SRC-1:0] src_c;
    logic [NUM_SRC-1:0] clr_c;
    logic [NUM_SRC-1:0] pend;

    assign reg_wr_c = cs && wr && ce;

`ifdef M92_RASTER_IRQ_EN
    logic [RASTER_W-1:0] raster_q, raster_d;
    logic [RASTER_W-1:0] vcount_q, vcount_d;

    // Raster register writes and previous-line history
    always_comb begin
        raster_d = raster_q;
        vcount_d = vcount_q;
        if (ce) begin
            vcount_d = vcount;
        end
        if (reg_wr_c && a == REG_RASTER_LO) begin
            raster_d[7:0] = din;
        end
        if (reg_wr_c && a == REG_RASTER_HI) begin
            raster_d[8] = din[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raster_q <= RASTER_RESET;
            vcount_q <= '0;
        end else begin
            raster_q <= raster_d;
            vcount_q <= vcount_d;
        end
    end

    // Match only when the line changes, so a write onto the current line is silent
    assign raster_match_c = (vcount == raster_q) && (vcount != vcount_q);

    logic unused_ok;
    assign unused_ok = ^pic_int_vector[1:0];
`else
    assign raster_match_c = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{vcount, din[7:4], pic_int_vector[1:0]};
`endif

    assign src_c[IRQ_VBLANK] = vblank;
    assign src_c[IRQ_DMA]    = dma_done;
    assign src_c[IRQ_RASTER] = raster_match_c;
    assign src_c[IRQ_SOUND]  = snd_irq;

    // Register clear plus auto-clear of the acknowledged level when it is local (< 4)
    always_comb begin
        clr_c = '0;
        if (reg_wr_c && a == REG_PEND_CLR) begin
            clr_c = din[3:0];
        end
        if (state_q == ST_ACK2 && !vec_q[2]) begin
            clr_c = clr_c | 4'(4'b0001 << vec_q[1:0]);
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        m92_irq_source u_src (
            .clk   (clk),
            .reset (reset),
            .ce    (ce),
            .src   (src_c[i]),
            .clr   (clr_c[i]),
            .pend  (pend[i])
        );
    end

    // INTA handshake next-state and registered outputs
    always_comb begin
        state_d   = state_q;
        cpu_int_d = cpu_int_q;
        ack_d     = ack_q;
        oe_d      = oe_q;
        vec_d     = vec_q;
        ext_d     = ext_q;
        if (ce) begin
            ext_d = ext_intp;
            case (state_q)
                ST_IDLE: if (pic_int_req) state_d = ST_REQ;
                ST_REQ: begin
                    if (!pic_int_req)  state_d = ST_IDLE;
                    else if (cpu_inta) state_d = ST_ACK1;
                end
                ST_ACK1: begin
                    if (!pic_int_req) begin
                        state_d = ST_IDLE;
                    end else if (cpu_inta) begin
                        state_d = ST_ACK2;
                        vec_d   = {1'b0, pic_int_vector[8:2]};
                    end
                end
                ST_ACK2: state_d = ST_WAIT;
                ST_WAIT: if (!pic_int_req) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            cpu_int_d = (state_d == ST_REQ);
            ack_d     = (state_d == ST_ACK2);
            oe_d      = (state_d == ST_ACK2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cpu_int_q <= 1'b0;
            ack_q     <= 1'b0;
            oe_q      <= 1'b0;
            vec_q     <= '0;
            ext_q     <= '0;
        end else begin
            state_q   <= state_d;
            cpu_int_q <= cpu_int_d;
            ack_q     <= ack_d;
            oe_q      <= oe_d;
            vec_q     <= vec_d;
            ext_q     <= ext_d;
        end
    end

    assign intp          = {ext_q, pend};
    assign cpu_int       = cpu_int_q;
    assign pic_int_ack   = ack_q;
    assign cpu_vector    = vec_q;
    assign cpu_vector_oe = oe_q;

endmodule

// File: tb/tb_m92_int_ctrl.sv
// tb_m92_int_ctrl: directed self-checking bench for m92_int_ctrl.
module tb_m92_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       cs;
    logic       wr;
    logic [1:0] a;
    logic [7:0] din;
    logic       vblank;
    logic [8:0] vcount;
    logic       dma_done;
    logic       snd_irq;
    logic [3:0] ext_intp;
    logic [7:0] intp;
    logic       pic_int_req;
    logic [8:0] pic_int_vector;
    logic       pic_int_ack;
    logic       cpu_int;
    logic       cpu_inta;
    logic [7:0] cpu_vector;
    logic       cpu_vector_oe;

    int checks = 0;
    int errors = 0;

`ifdef M92_RASTER_IRQ_EN
    localparam logic RASTER_ON = 1'b1;
`else
    localparam logic RASTER_ON = 1'b0;
`endif

    m92_int_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ce             (ce),
        .cs             (cs),
        .wr             (wr),
        .a              (a),
        .din            (din),
        .vblank         (vblank),
        .vcount         (vcount),
        .dma_done       (dma_done),
        .snd_irq        (snd_irq),
        .ext_intp       (ext_intp),
        .intp           (intp),
        .pic_int_req    (pic_int_req),
        .pic_int_vector (pic_int_vector),
        .pic_int_ack    (pic_int_ack),
        .cpu_int        (cpu_int),
        .cpu_inta       (cpu_inta),
        .cpu_vector     (cpu_vector),
        .cpu_vector_oe  (cpu_vector_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
        cs = 1'b1; wr = 1'b1; a = addr; din = data;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; cs = 1'b0; wr = 1'b0; a = 2'd0; din = 8'h00;
        vblank = 1'b0; vcount = 9'h000; dma_done = 1'b0; snd_irq = 1'b0;
        ext_intp = 4'h0; pic_int_req = 1'b0; pic_int_vector = 9'h000; cpu_inta = 1'b0;

        #2;
        check("rst_intp",   32'(intp),          32'h00);
        check("rst_cpuint", 32'(cpu_int),       32'h0);
        check("rst_ack",    32'(pic_int_ack),   32'h0);
        check("rst_vec",    32'(cpu_vector),    32'h00);
        check("rst_oe",     32'(cpu_vector_oe), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // vblank edge stalls while ce is low, lands one ce later
        vblank = 1'b1; ce = 1'b0;
        tick();
        check("ce_stall", 32'(intp[0]), 32'h0);
        ce = 1'b1;
        tick();
        check("vblank_set", 32'(intp[0]), 32'h1);

        // Full INTA handshake, vector level 0
        pic_int_req = 1'b1; pic_int_vector = 9'h080;
        tick();
        check("cpu_int_req", 32'(cpu_int), 32'h1);
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        check("cpu_int_ack1", 32'(cpu_int), 32'h0);
        tick();
        check("oe_in_ack1", 32'(cpu_vector_oe), 32'h0);
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        check("vec_ack2",  32'(cpu_vector),    32'h20);
        check("oe_ack2",   32'(cpu_vector_oe), 32'h1);
        check("ack_ack2",  32'(pic_int_ack),   32'h1);
        check("p0_ack2",   32'(intp[0]),       32'h1);
        tick();
        check("oe_wait",   32'(cpu_vector_oe), 32'h0);
        check("ack_wait",  32'(pic_int_ack),   32'h0);
        check("p0_autoclr", 32'(intp[0]),      32'h0);
        pic_int_req = 1'b0; vblank = 1'b0;
        tick();

        // Stray INTA in IDLE
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        check("stray_int", 32'(cpu_int),       32'h0);
        check("stray_oe",  32'(cpu_vector_oe), 32'h0);
        check("stray_ack", 32'(pic_int_ack),   32'h0);
        check("stray_vec", 32'(cpu_vector),    32'h20);

        // ext_intp registered through
        ext_intp = 4'hA;
        #1;
        check("ext_pre",  32'(intp[7:4]), 32'h0);
        tick();
        check("ext_post", 32'(intp[7:4]), 32'hA);

        // Raster compare
        reg_write(2'd0, 8'hF0);
        reg_write(2'd1, 8'h00);
        vcount = 9'h0EF;
        tick();
        check("raster_pre", 32'(intp[2]), 32'h0);
        vcount = 9'h0F0;
        tick();
        check("raster_hit", 32'(intp[2]), 32'(RASTER_ON));
        reg_write(2'd2, 8'h04);
        check("raster_clr", 32'(intp[2]), 32'h0);
        tick();
        tick();
        check("raster_hold", 32'(intp[2]), 32'h0);
        vcount = 9'h055;
        tick();
        reg_write(2'd0, 8'h55);
        tick();
        check("raster_sameline", 32'(intp[2]), 32'h0);

        // DMA and sound, set beats clear
        dma_done = 1'b1; snd_irq = 1'b1;
        tick();
        check("dma_set", 32'(intp[1]), 32'h1);
        check("snd_set", 32'(intp[3]), 32'h1);
        dma_done = 1'b0;
        tick();
        dma_done = 1'b1;
        reg_write(2'd2, 8'h02);
        check("set_wins", 32'(intp[1]), 32'h1);
        check("snd_keep", 32'(intp[3]), 32'h1);
        reg_write(2'd2, 8'h08);
        check("snd_clr", 32'(intp[3]), 32'h0);
        check("dma_keep", 32'(intp[1]), 32'h1);
        reg_write(2'd2, 8'h02);
        check("dma_clr", 32'(intp[1]), 32'h0);

        // PIC withdraws the request during ACK1
        pic_int_req = 1'b1; pic_int_vector = 9'h08C;
        tick();
        check("abort_req", 32'(cpu_int), 32'h1);
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        pic_int_req = 1'b0;
        tick();
        check("abort_int", 32'(cpu_int),     32'h0);
        check("abort_ack", 32'(pic_int_ack), 32'h0);
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        check("abort_idle_ack", 32'(pic_int_ack),   32'h0);
        check("abort_idle_oe",  32'(cpu_vector_oe), 32'h0);
        check("abort_vec",      32'(cpu_vector),    32'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
